// File: rtl/spi_tx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : spi_tx_pkg                                                 |
// | Purpose : Shared constants, state encoding and helpers for the SPI   |
// |           sample transmitter.                                        |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package spi_tx_pkg;

  // Default SPI word size (one ADC sample per transaction).
  localparam int WORD_W = 16;

  // Bit-counter width for a given word size: one spare bit so the counter
  // can reach and exceed WORD_W when the host sends extra clocks.
  function automatic int cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int CNT_W = cnt_w(WORD_W);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    READY = 3'd2,
    SHIFT = 3'd3,
    END   = 3'd4
  } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/sample_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : sample_fifo                                                |
// | Purpose : Synchronous show-ahead FIFO; head word visible without a   |
// |           read strobe. Pointers carry one wrap bit for full/empty.   |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module sample_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_wr_en,
  input  logic [WIDTH-1:0]           i_wr_data,
  input  logic                       i_rd_en,
  output logic [WIDTH-1:0]           o_rd_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_wr;
  logic             w_do_rd;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

  // A write into a full FIFO is legal only when the head is leaving the
  // same cycle; the freed slot is the one being written.
  assign w_do_wr = i_wr_en && (!o_full || i_rd_en);
  assign w_do_rd = i_rd_en && !o_empty;

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

  // Read/write pointers with natural wrap-around.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_sample_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : spi_sample_tx                                              |
// | Purpose : SPI mode-0 slave transmitter returning buffered ADC        |
// |           samples MSB-first; FIFO fed by a valid/ready write port.   |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module spi_sample_tx #(
  parameter int DEPTH  = 8,
  parameter int WORD_W = spi_tx_pkg::WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [WORD_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              sclk,
  input  logic              SPI_cs,
  output logic              processed_miso,
  output logic              SPI_RDY,
  output logic [7:0]        ovf_count
);

  import spi_tx_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(WORD_W);

  tx_state_t         r_state;
  tx_state_t         w_next;
  logic [2:0]        r_sclk_sync;
  logic [2:0]        r_cs_sync;
  logic [WORD_W-1:0] r_shift;
  logic [CW-1:0]     r_cnt;
  logic [7:0]        r_ovf;

  logic              w_sclk_rise;
  logic              w_sclk_fall;
  logic              w_cs_rise;
  logic              w_cs_fall;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_nonempty_after;
  logic [WORD_W-1:0] w_head;
  logic [AW:0]       w_count;

  sample_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_push),
    .i_wr_data (wr_data),
    .i_rd_en   (w_pop),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_count)
  );

  // Two-stage synchronizers plus one history stage for edge detection;
  // idle levels (sclk low, cs high) are restored on reset so no false edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sclk_sync <= 3'b000;
      r_cs_sync   <= 3'b111;
    end else begin
      r_sclk_sync <= {r_sclk_sync[1:0], sclk};
      r_cs_sync   <= {r_cs_sync[1:0], SPI_cs};
    end
  end

  assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
  assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_sync[2];
  assign w_cs_rise   = r_cs_sync[1] & ~r_cs_sync[2];
  assign w_cs_fall   = ~r_cs_sync[1] & r_cs_sync[2];

  // Pop only from registered state, so wr_ready has no input-to-output path.
  assign w_pop    = (r_state == END) && (r_cnt >= CW'(WORD_W));
  assign wr_ready = !w_full || w_pop;
  assign w_push   = wr_valid && wr_ready;

  // Occupancy after this cycle's push/pop decides whether END reloads.
  assign w_nonempty_after = w_push || (w_count > {{AW{1'b0}}, w_pop});

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (!w_empty) w_next = LOAD;
      LOAD:    w_next = READY;
      READY:   if (w_cs_fall) w_next = SHIFT;
      SHIFT:   if (w_cs_rise) w_next = END;
      END:     w_next = w_nonempty_after ? LOAD : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Shift register and bit counter: load head in LOAD, count rises and
  // shift on falls while the transaction is open. Counter saturates so a
  // long burst of extra clocks still reads as delivered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        LOAD: begin
          r_shift <= w_head;
          r_cnt   <= '0;
        end
        SHIFT: begin
          if (w_sclk_rise && (r_cnt != {CW{1'b1}})) r_cnt <= r_cnt + CW'(1);
          if (w_sclk_fall) r_shift <= {r_shift[WORD_W-2:0], 1'b0};
        end
        default: ;
      endcase
    end
  end

  // Saturating count of words dropped because the FIFO was full.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                       r_ovf <= 8'd0;
    else if (wr_valid && !wr_ready && r_ovf != 8'hFF) r_ovf <= r_ovf + 8'd1;
  end

  assign ovf_count      = r_ovf;
  assign SPI_RDY        = (r_state == READY);
  assign processed_miso = ((r_state == READY) || (r_state == SHIFT)) ?
                          r_shift[WORD_W-1] : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_spi_sample_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_spi_sample_tx                                           |
// | Purpose : Directed self-checking bench for spi_sample_tx with a      |
// |           simple SPI mode-0 host model.                              |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_spi_sample_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_valid = 1'b0;
  logic [15:0] wr_data = 16'h0000;
  logic        wr_ready;
  logic        sclk = 1'b0;
  logic        SPI_cs = 1'b1;
  logic        processed_miso;
  logic        SPI_RDY;
  logic [7:0]  ovf_count;

  int n_cmp = 0;
  int n_err = 0;

  spi_sample_tx #(.DEPTH(8), .WORD_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_valid       (wr_valid),
    .wr_data        (wr_data),
    .wr_ready       (wr_ready),
    .sclk           (sclk),
    .SPI_cs         (SPI_cs),
    .processed_miso (processed_miso),
    .SPI_RDY        (SPI_RDY),
    .ovf_count      (ovf_count)
  );

  // 10 ns system clock.
  always #5 clk = ~clk;

  // Hard stop if the directed sequence ever stalls.
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n clocks; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [15:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    step(1);
    wr_valid = 1'b0;
  endtask

  // One SPI bit: sample MISO at the rising edge, 4-clk half periods.
  task automatic sclk_bit(output logic b);
    sclk = 1'b1;
    b    = processed_miso;
    step(4);
    sclk = 1'b0;
    step(4);
  endtask

  // Host transaction with nrise clocks. Optionally offers a write exactly
  // in the END cycle (three clocks after the cs rise). Returns after the
  // LOAD cycle that follows END.
  task automatic xfer(input int nrise, input logic do_wr, input logic [15:0] wd,
                      output logic [15:0] rx);
    logic b;
    rx = 16'h0000;
    SPI_cs = 1'b0;
    step(4);
    for (int i = 0; i < nrise; i++) begin
      sclk_bit(b);
      rx = {rx[14:0], b};
    end
    SPI_cs = 1'b1;
    step(3);
    if (do_wr) begin
      chk("wr_ready_in_end", {31'd0, wr_ready}, 32'd1);
      wr_valid = 1'b1;
      wr_data  = wd;
    end
    step(1);
    wr_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] rx;
    logic        b;

    // ---------------- reset state ----------------
    step(2);
    chk("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
    chk("rst_spi_rdy", {31'd0, SPI_RDY}, 32'd0);
    chk("rst_miso", {31'd0, processed_miso}, 32'd0);
    chk("rst_ovf", {24'd0, ovf_count}, 32'd0);
    rst = 1'b1;
    step(2);

    // ---------------- single word A5C3 ----------------
    wr(16'hA5C3);
    chk("t1_rdy_load", {31'd0, SPI_RDY}, 32'd0);
    step(1);
    chk("t1_rdy_n1", {31'd0, SPI_RDY}, 32'd0);
    step(1);
    chk("t1_rdy_n2", {31'd0, SPI_RDY}, 32'd1);
    chk("t1_miso_b15", {31'd0, processed_miso}, 32'd1);
    xfer(16, 1'b0, 16'h0, rx);
    chk("t1_rx", {16'd0, rx}, 32'h0000A5C3);
    step(1);
    chk("t1_rdy_after", {31'd0, SPI_RDY}, 32'd0);
    chk("t1_miso_idle", {31'd0, processed_miso}, 32'd0);
    chk("t1_wr_ready", {31'd0, wr_ready}, 32'd1);

    // ---------------- three back-to-back words ----------------
    wr(16'h0001);
    wr(16'h8000);
    wr(16'hFFFF);
    step(1);
    chk("t2_rdy0", {31'd0, SPI_RDY}, 32'd1);
    xfer(16, 1'b0, 16'h0, rx);
    chk("t2_rx0", {16'd0, rx}, 32'h00000001);
    chk("t2_load0", {31'd0, SPI_RDY}, 32'd0);
    step(1);
    chk("t2_rerise0", {31'd0, SPI_RDY}, 32'd1);
    chk("t2_miso_b15_1", {31'd0, processed_miso}, 32'd1);
    xfer(16, 1'b0, 16'h0, rx);
    chk("t2_rx1", {16'd0, rx}, 32'h00008000);
    step(1);
    chk("t2_rerise1", {31'd0, SPI_RDY}, 32'd1);
    xfer(16, 1'b0, 16'h0, rx);
    chk("t2_rx2", {16'd0, rx}, 32'h0000FFFF);
    step(1);
    chk("t2_rdy_empty", {31'd0, SPI_RDY}, 32'd0);

    // ---------------- aborted transaction ----------------
    wr(16'h1234);
    step(2);
    xfer(7, 1'b0, 16'h0, rx);
    chk("t3_partial", {16'd0, rx}, 32'h00000009);
    step(1);
    chk("t3_rdy_kept", {31'd0, SPI_RDY}, 32'd1);
    xfer(16, 1'b0, 16'h0, rx);
    chk("t3_rx_retry", {16'd0, rx}, 32'h00001234);
    step(1);
    chk("t3_rdy_empty", {31'd0, SPI_RDY}, 32'd0);

    // ---------------- overflow: 10 writes into depth 8 ----------------
    for (int k = 0; k < 10; k++) begin
      wr(16'hC000 + 16'(k));
      if (k == 6) chk("t4_ready_after7", {31'd0, wr_ready}, 32'd1);
      if (k == 7) chk("t4_ready_after8", {31'd0, wr_ready}, 32'd0);
    end
    step(1);
    chk("t4_ovf", {24'd0, ovf_count}, 32'd2);
    chk("t4_rdy", {31'd0, SPI_RDY}, 32'd1);

    // ---------------- write + pop same cycle while full ----------------
    xfer(16, 1'b1, 16'hD00D, rx);
    chk("t5_rx0", {16'd0, rx}, 32'h0000C000);
    chk("t5_still_full", {31'd0, wr_ready}, 32'd0);
    chk("t5_no_ovf", {24'd0, ovf_count}, 32'd2);
    step(1);
    for (int k = 1; k < 8; k++) begin
      xfer(16, 1'b0, 16'h0, rx);
      chk($sformatf("t5_rx%0d", k), {16'd0, rx}, 32'hC000 + k);
      step(1);
    end
    xfer(16, 1'b0, 16'h0, rx);
    chk("t5_rx_new", {16'd0, rx}, 32'h0000D00D);
    step(1);
    chk("t5_rdy_empty", {31'd0, SPI_RDY}, 32'd0);
    chk("t5_wr_ready", {31'd0, wr_ready}, 32'd1);

    // ---------------- reset during bit 9 ----------------
    wr(16'hBEEF);
    step(2);
    SPI_cs = 1'b0;
    step(4);
    for (int i = 0; i < 8; i++) sclk_bit(b);
    sclk = 1'b1;
    step(2);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rdy_async", {31'd0, SPI_RDY}, 32'd0);
    chk("t6_miso_async", {31'd0, processed_miso}, 32'd0);
    chk("t6_ovf_async", {24'd0, ovf_count}, 32'd0);
    chk("t6_wr_ready_async", {31'd0, wr_ready}, 32'd1);
    sclk   = 1'b0;
    SPI_cs = 1'b1;
    step(2);
    rst = 1'b1;
    step(10);
    chk("t6_no_stale_rdy", {31'd0, SPI_RDY}, 32'd0);
    chk("t6_no_stale_miso", {31'd0, processed_miso}, 32'd0);
    wr(16'h5A5A);
    step(2);
    xfer(16, 1'b0, 16'h0, rx);
    chk("t6_rx_fresh", {16'd0, rx}, 32'h00005A5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
